// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a_in - b_in - bin, one bit per clock, LSB first, valid/ready on both sides.
// Build option SERIAL_SUB_SAT_EN: when defined, a borrowing result presents diff = 0 (floor saturation).
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   diff_r;
  logic               br_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               bout_r;
  logic [1:0]         fs_s;
  logic               accept_s;
  logic               last_s;
  logic [WIDTH-1:0]   diff_shift_s;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
    full_sub = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
  endfunction

  assign fs_s         = full_sub(a_r[0], b_r[0], br_r);
  assign accept_s     = in_valid && in_ready_r;
  assign last_s       = (cnt_r == CNT_W'(WIDTH - 1));
  assign diff_shift_s = {fs_s[0], diff_r[WIDTH-1:1]};

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign diff      = diff_r;
  assign bout      = bout_r;

  // Next-state selection for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = SHIFT;
        else          state_next_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = SHIFT;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      diff_r      <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      br_r        <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      // Handshake flags follow the state being entered so they are valid in that state's first cycle.
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r    <= a_in;
            b_r    <= b_in;
            br_r   <= bin;
            cnt_r  <= {CNT_W{1'b0}};
            bout_r <= 1'b0;
          end
        end
        SHIFT: begin
          a_r   <= {1'b0, a_r[WIDTH-1:1]};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          br_r  <= fs_s[1];
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_s) begin
            bout_r <= fs_s[1];
`ifdef SERIAL_SUB_SAT_EN
            diff_r <= fs_s[1] ? {WIDTH{1'b0}} : diff_shift_s;
`else
            diff_r <= diff_shift_s;
`endif
          end else begin
            diff_r <= diff_shift_s;
          end
        end
        DONE: begin
          diff_r <= diff_r;
        end
        default: begin
          diff_r <= diff_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, mid-op reset and randomized ops
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .bin(bin), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .bout(bout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow is the sign of the result.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int d;
    logic [31:0] dv;
    logic [W-1:0] r;
    logic br;
    d  = int'(a) - int'(b) - int'(bi);
    dv = d;
    r  = dv[W-1:0];
    br = (int'(a) < int'(b) + int'(bi));
`ifdef SERIAL_SUB_SAT_EN
    if (br) r = '0;
`endif
    return {br, r};
  endfunction

  // One complete operation: optional idle gap, accept, latency check, hold in DONE, consume.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input int gap, input int hold, input bit noise);
    logic [W:0] exp;
    logic [W-1:0] held;
    int n;
    exp = ref_sub(a, b, bi);
    for (int i = 0; i < gap; i++) tick();
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a_in = a; b_in = b; bin = bi; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_in_shift", 32'(busy), 32'd1);
    chk("in_ready_in_shift", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a_in = W'($urandom); b_in = W'($urandom); bin = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    chk("diff", 32'(diff), 32'(exp[W-1:0]));
    chk("bout", 32'(bout), 32'(exp[W]));
    held = diff;
    for (int i = 0; i < hold; i++) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      tick();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_diff", 32'(diff), 32'(held));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; bin = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    tick();

    do_op(8'h5A, 8'h21, 1'b0, 0, 0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 0, 1, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1, 1, 0, 1'b0);
    do_op(8'h00, 8'hFF, 1'b1, 0, 0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 0, 0, 1'b0);
    do_op(8'hFF, 8'h00, 1'b0, 0, 0, 1'b0);
    // Long stall in DONE with in_valid toggling during SHIFT and DONE.
    do_op(8'hC3, 8'h3C, 1'b0, 0, 5, 1'b1);

    // Simultaneous out_ready and in_valid in DONE: result consumed, new operands not accepted.
    a_in = 8'h20; b_in = 8'h10; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    chk("sim_out_valid", 32'(out_valid), 32'd1);
    chk("sim_diff", 32'(diff), 32'h10);
    a_in = 8'h44; b_in = 8'h11; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sim_in_ready_after", 32'(in_ready), 32'd1);
    chk("sim_busy_after", 32'(busy), 32'd0);
    tick(); tick();
    chk("sim_no_extra_busy", 32'(busy), 32'd0);
    chk("sim_no_extra_valid", 32'(out_valid), 32'd0);

    // Reset during the third SHIFT cycle aborts the operation.
    a_in = 8'h77; b_in = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    do_op(8'h10, 8'h01, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
